// File: rtl/jtkcpu_intctl.sv
// jtkcpu_intctl: KONAMI-1 interrupt controller (clk/rst_n/cen; cs/we/addr/din/dout register window; irq_src/firq_src/nmi_src requests; intvec CPU ack; irq_n/firq_n/nmi_n to CPU); interval timer built only with JTKCPU_INTCTL_TIMER_EN
module jtkcpu_intctl #(
  parameter int NMI_W   = 4,
  parameter bit AUTOACK = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       irq_src,
  input  logic       firq_src,
  input  logic       nmi_src,
  input  logic [3:0] intvec,
  output logic       irq_n,
  output logic       firq_n,
  output logic       nmi_n
);
`ifdef JTKCPU_INTCTL_TIMER_EN
  localparam logic [3:0] EN_MASK = 4'hf;
`else
  localparam logic [3:0] EN_MASK = 4'h7;
`endif
  logic [2:0] src, src_q, edg, ack, clr, set, pend, pend_nx;
  logic [3:0] en, iv_q, nmi_cnt, nmi_cnt_nx;
  logic [15:0] cnt;
  logic wr0, wr1, wr2, wr3, tmr_exp, ovf;
  logic nmi_act, nmi_fin, nmi_abort, nmi_start, nmi_again, nmi_again_nx, nmi_n_nx;
  always_comb begin
    src          = {nmi_src, firq_src, irq_src};
    edg          = src & ~src_q;
    wr0          = cs & we & (addr == 2'd0);
    wr1          = cs & we & (addr == 2'd1);
    wr2          = cs & we & (addr == 2'd2);
    wr3          = cs & we & (addr == 2'd3);
    ack          = (AUTOACK && iv_q == 4'd0) ? intvec[2:0] : 3'b0;
    nmi_act      = nmi_cnt != 4'd0;
    nmi_abort    = wr0 & ~din[2] & nmi_act;
    nmi_fin      = (nmi_cnt == 4'd1) & ~nmi_abort;
    nmi_start    = pend[2] & en[2] & ~nmi_act;
    clr          = ({3{wr1}} & din[2:0]) | ack | {nmi_abort, 2'b0};
    set          = edg | {1'b0, tmr_exp, 1'b0};
    pend_nx[1:0] = set[1:0] | (pend[1:0] & ~clr[1:0]);
    pend_nx[2]   = set[2] | ((nmi_fin ? nmi_again : pend[2]) & ~clr[2]);
    nmi_again_nx = nmi_act & ~nmi_fin & ~clr[2] & (nmi_again | edg[2]);
    nmi_cnt_nx   = nmi_abort ? 4'd0 : nmi_start ? 4'(NMI_W) : nmi_act ? nmi_cnt - 4'd1 : nmi_cnt;
    nmi_n_nx     = (nmi_abort | nmi_fin) ? 1'b1 : nmi_start ? 1'b0 : nmi_n;
    dout         = addr == 2'd0 ? {4'b0, en} :
                   addr == 2'd1 ? {ovf, 4'b0, pend} :
                   addr == 2'd2 ? cnt[7:0] : cnt[15:8];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      src_q     <= 3'b0;
      iv_q      <= 4'b0;
      en        <= 4'b0;
      pend      <= 3'b0;
      irq_n     <= 1'b1;
      firq_n    <= 1'b1;
      nmi_n     <= 1'b1;
      nmi_cnt   <= 4'd0;
      nmi_again <= 1'b0;
    end else if (cen) begin
      src_q     <= src;
      iv_q      <= intvec;
      en        <= wr0 ? din[3:0] & EN_MASK : en;
      pend      <= pend_nx;
      irq_n     <= ~(pend[0] & en[0]);
      firq_n    <= ~(pend[1] & en[1]);
      nmi_n     <= nmi_n_nx;
      nmi_cnt   <= nmi_cnt_nx;
      nmi_again <= nmi_again_nx;
    end
`ifdef JTKCPU_INTCTL_TIMER_EN
  logic [15:0] rld;
  assign tmr_exp = en[3] & (cnt == 16'd0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= 16'd0;
      rld <= 16'd0;
      ovf <= 1'b0;
    end else if (cen) begin
      if (wr2) rld[7:0] <= din;
      if (wr3) rld[15:8] <= din;
      cnt <= wr3 ? {din, rld[7:0]} : !en[3] ? cnt : tmr_exp ? rld : cnt - 16'd1;
      ovf <= (tmr_exp & pend[1]) | (ovf & ~(wr1 & din[7]));
    end
`else
  logic unused_din;
  assign unused_din = ^{din[6:3], wr2, wr3};
  assign tmr_exp    = 1'b0;
  assign cnt        = 16'd0;
  assign ovf        = 1'b0;
`endif
endmodule
